// File: rtl/fpu_issue_pkg.sv
// Shared encodings for the RV32F issue/writeback controller.
// The FPU_WATCHDOG_EN build adds a WAIT-state timeout (see fpu_watchdog).
package fpu_issue_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } issue_state_e;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // Codes 4-7 are reserved, so the top opcode bit alone identifies them.
  function automatic logic op_is_reserved(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/fpu_watchdog.sv
// WAIT-state cycle counter; flags a timeout on the last allowed WAIT cycle.
// Instantiated by fpu_issue_ctrl only when FPU_WATCHDOG_EN is defined.
module fpu_watchdog
  import fpu_issue_pkg::*;
#(
  parameter int unsigned WD_CYCLES = 1024,
  parameter int unsigned CNT_W     = 11
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_timeout
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_timeout = i_run && (r_count == CNT_W'(WD_CYCLES - 1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-op issue/writeback controller between RV32F execute and the FPU units.
// Define FPU_WATCHDOG_EN to bound the WAIT state with fpu_watchdog.
module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int unsigned WD_CYCLES = 1024,
  parameter int unsigned CNT_W     = 11
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_op,
  input  logic [4:0]  i_req_rd,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  output logic [31:0] o_operand_a,
  output logic [31:0] o_operand_b,
  output logic        o_add_start,
  output logic        o_add_sel,
  output logic        o_mul_start,
  output logic        o_div_start,
  input  logic        i_add_done,
  input  logic        i_mul_done,
  input  logic        i_div_done,
  input  logic [31:0] i_add_result,
  input  logic [31:0] i_mul_result,
  input  logic [31:0] i_div_result,
  output logic        o_wb_valid,
  input  logic        i_wb_ready,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_wb_err,
  output logic        o_busy
);

  issue_state_e r_state;
  fpu_op_e      r_op;
  logic         r_req_ready, r_busy;
  logic         r_add_start, r_mul_start, r_div_start, r_add_sel;
  logic         r_wb_valid, r_wb_err;
  logic [4:0]   r_wb_rd;
  logic [31:0]  r_operand_a, r_operand_b, r_wb_data;

  logic         w_sel_done;
  logic [31:0]  w_sel_result;
  logic         w_timeout;

  // Only the unit that was started is listened to; the other done lines are noise.
  always_comb begin
    w_sel_done   = 1'b0;
    w_sel_result = i_add_result;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_sel_done   = i_add_done;
        w_sel_result = i_add_result;
      end
      OP_MUL: begin
        w_sel_done   = i_mul_done;
        w_sel_result = i_mul_result;
      end
      OP_DIV: begin
        w_sel_done   = i_div_done;
        w_sel_result = i_div_result;
      end
      default: ;
    endcase
  end

`ifdef FPU_WATCHDOG_EN
  fpu_watchdog #(
    .WD_CYCLES(WD_CYCLES),
    .CNT_W    (CNT_W)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (r_state == ST_ISSUE),
    .i_run    (r_state == ST_WAIT),
    .o_timeout(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
  logic w_unused_wd;
  assign w_unused_wd = ^{WD_CYCLES, CNT_W};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_ADD;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_add_start <= 1'b0;
      r_mul_start <= 1'b0;
      r_div_start <= 1'b0;
      r_add_sel   <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_err    <= 1'b0;
      r_wb_rd     <= '0;
      r_operand_a <= '0;
      r_operand_b <= '0;
      r_wb_data   <= '0;
    end else begin
      r_add_start <= 1'b0;
      r_mul_start <= 1'b0;
      r_div_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_wb_rd     <= i_req_rd;
            r_operand_a <= i_req_a;
            r_operand_b <= i_req_b;
            r_add_sel   <= (i_req_op == OP_SUB);
            if (op_is_reserved(i_req_op)) begin
              r_wb_valid <= 1'b1;
              r_wb_err   <= 1'b1;
              r_wb_data  <= CANON_NAN;
              r_state    <= ST_WB;
            end else begin
              r_op        <= fpu_op_e'(i_req_op);
              r_add_start <= (i_req_op == OP_ADD) || (i_req_op == OP_SUB);
              r_mul_start <= (i_req_op == OP_MUL);
              r_div_start <= (i_req_op == OP_DIV);
              r_wb_err    <= 1'b0;
              r_state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (w_sel_done) begin
            r_wb_data  <= w_sel_result;
            r_wb_valid <= 1'b1;
            r_state    <= ST_WB;
          end else if (w_timeout) begin
            r_wb_data  <= CANON_NAN;
            r_wb_err   <= 1'b1;
            r_wb_valid <= 1'b1;
            r_state    <= ST_WB;
          end
        end
        ST_WB: begin
          if (i_wb_ready) begin
            r_wb_valid  <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_busy      = r_busy;
  assign o_operand_a = r_operand_a;
  assign o_operand_b = r_operand_b;
  assign o_add_start = r_add_start;
  assign o_add_sel   = r_add_sel;
  assign o_mul_start = r_mul_start;
  assign o_div_start = r_div_start;
  assign o_wb_valid  = r_wb_valid;
  assign o_wb_rd     = r_wb_rd;
  assign o_wb_data   = r_wb_data;
  assign o_wb_err    = r_wb_err;

endmodule
